// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: state encodings, op classes, next-PC selects and reset/vector defaults for pc_ctrl.
package pc_ctrl_pkg;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_EXC    = 3'd6
  } state_t;
  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JREG   = 3'd3,
    OP_LOAD   = 3'd4,
    OP_STORE  = 3'd5,
    OP_MULDIV = 3'd6,
    OP_TRAP   = 3'd7
  } op_t;
  typedef enum logic [2:0] {
    NPC_SEQ = 3'd0,
    NPC_BR  = 3'd1,
    NPC_J   = 3'd2,
    NPC_JR  = 3'd3,
    NPC_VEC = 3'd4,
    NPC_EPC = 3'd5
  } npc_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC select; every loaded target is word-aligned.
module pc_next_mux import pc_ctrl_pkg::*; (
  input  npc_t        sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] btarget_i,
  input  logic [31:0] jtarget_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] vec_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o
);
  logic [31:0] tgt;
  always_comb begin
    tgt   = sel_i == NPC_BR  ? btarget_i :
            sel_i == NPC_J   ? jtarget_i :
            sel_i == NPC_JR  ? rs_val_i  :
            sel_i == NPC_VEC ? vec_i     : epc_i;
    npc_o = sel_i == NPC_SEQ ? pc_i + 32'd4 : tgt & 32'hFFFF_FFFC;
  end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB/MDWAIT) owning the PC.
// Define PC_CTRL_EXC_EN to add the EXC state, trap vector and eret return path.
module pc_ctrl import pc_ctrl_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef PC_CTRL_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic [2:0]  op_class,
  input  logic        link,
  input  logic        br_taken,
  input  logic [31:0] btarget,
  input  logic [31:0] jtarget,
  input  logic [31:0] rs_val,
  output logic        md_start,
  input  logic        md_busy,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
`ifdef PC_CTRL_EXC_EN
  input  logic        eret,
  input  logic [31:0] epc_in,
  output logic        exc_take,
  output logic [31:0] epc_out,
`endif
  output logic [2:0]  state
);
  state_t      state_q, state_d;
  op_t         cls_q;
  logic        link_q, pc_we;
  logic [31:0] pc_q, npc, vec, epc_src;
  npc_t        sel;
`ifdef PC_CTRL_EXC_EN
  logic        eret_q, epc_we;
  logic [31:0] epc_q;
  assign vec     = EXC_VECTOR;
  assign epc_src = epc_in;
`else
  assign vec     = 32'h0;
  assign epc_src = 32'h0;
`endif
  pc_next_mux u_mux (
    .sel_i(sel), .pc_i(pc_q), .btarget_i(btarget), .jtarget_i(jtarget),
    .rs_val_i(rs_val), .vec_i(vec), .epc_i(epc_src), .npc_o(npc)
  );
  always_comb begin
    state_d = state_q;
    sel     = NPC_SEQ;
    pc_we   = 1'b0;
`ifdef PC_CTRL_EXC_EN
    epc_we  = 1'b0;
`endif
    case (state_q)
      S_FETCH:  begin
        state_d = imem_ack ? S_DECODE : S_FETCH;
        pc_we   = imem_ack;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   case (cls_q)
        OP_ALU:    state_d = S_WB;
        OP_BRANCH: begin
          sel   = NPC_BR;
          pc_we = br_taken;
          state_d = S_FETCH;
        end
        OP_JUMP, OP_JREG: begin
          sel   = cls_q == OP_JUMP ? NPC_J : NPC_JR;
          pc_we = 1'b1;
          state_d = link_q ? S_WB : S_FETCH;
        end
        OP_LOAD, OP_STORE: state_d = S_MEM;
        OP_MULDIV: state_d = S_MDWAIT;
`ifdef PC_CTRL_EXC_EN
        OP_TRAP:   state_d = S_EXC;
`endif
        default:   state_d = S_FETCH;
      endcase
      S_MEM:    state_d = !dmem_ack ? S_MEM : cls_q == OP_STORE ? S_FETCH : S_WB;
      S_MDWAIT: state_d = md_busy ? S_MDWAIT : S_FETCH;
      S_WB:     state_d = S_FETCH;
`ifdef PC_CTRL_EXC_EN
      S_EXC:    begin
        sel     = eret_q ? NPC_EPC : NPC_VEC;
        pc_we   = 1'b1;
        epc_we  = !eret_q;
        state_d = S_FETCH;
      end
`endif
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      cls_q   <= OP_ALU;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_we) pc_q <= npc;
      if (state_q == S_DECODE) begin
        cls_q  <= op_t'(op_class);
        link_q <= link;
      end
    end
`ifdef PC_CTRL_EXC_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      eret_q <= 1'b0;
      epc_q  <= 32'h0;
    end else begin
      if (state_q == S_DECODE) eret_q <= eret;
      if (epc_we) epc_q <= pc_q - 32'd4;
    end
  assign exc_take = !rst && state_q == S_EXC;
  assign epc_out  = epc_q;
`endif
  // Strobes are forced low while rst is high, since reset parks the FSM in FETCH.
  assign imem_rd  = !rst && state_q == S_FETCH;
  assign ir_we    = imem_rd && imem_ack;
  assign md_start = !rst && state_q == S_EXEC && cls_q == OP_MULDIV;
  assign dmem_req = !rst && state_q == S_MEM;
  assign dmem_we  = dmem_req && cls_q == OP_STORE;
  assign rf_we    = !rst && state_q == S_WB;
  assign pc       = pc_q;
  assign state    = state_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl; TRAP checks follow PC_CTRL_EXC_EN.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;
  logic        clk = 0, rst = 1, imem_ack = 0, link = 0, br_taken = 0, md_busy = 0, dmem_ack = 0;
  logic [2:0]  op_class = 0;
  logic [31:0] btarget = 0, jtarget = 0, rs_val = 0, pcx;
  logic        imem_rd, ir_we, md_start, dmem_req, dmem_we, rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
`ifdef PC_CTRL_EXC_EN
  logic        eret = 0, exc_take;
  logic [31:0] epc_in = 0, epc_out;
`endif
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  pc_ctrl dut (
    .clk(clk), .rst(rst), .imem_rd(imem_rd), .imem_ack(imem_ack), .ir_we(ir_we),
    .op_class(op_class), .link(link), .br_taken(br_taken), .btarget(btarget),
    .jtarget(jtarget), .rs_val(rs_val), .md_start(md_start), .md_busy(md_busy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we), .pc(pc),
`ifdef PC_CTRL_EXC_EN
    .eret(eret), .epc_in(epc_in), .exc_take(exc_take), .epc_out(epc_out),
`endif
    .state(state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  // Leaves the bench at the EXEC negedge with op_class/link scrambled to prove they were latched.
  task automatic fetch(input int w, input logic [2:0] cls, input logic lk, input logic [31:0] pc0);
    for (int i = 0; i < w; i++) begin
      check("fetch_wait_rd", imem_rd, 1);
      check("fetch_wait_pc", pc, pc0);
      tick();
    end
    check("fetch_state", state, S_FETCH);
    check("fetch_pc", pc, pc0);
    imem_ack = 1; op_class = cls; link = lk;
    #1 check("ir_we", ir_we, 1);
    tick();
    imem_ack = 0;
    check("decode_state", state, S_DECODE);
    check("pc_inc", pc, pc0 + 32'd4);
    check("ir_we_off", ir_we, 0);
    tick();
    op_class = 3'd0; link = 0;
    check("exec_state", state, S_EXEC);
  endtask
  initial begin
    tick(); tick();
    check("rst_imem_rd", imem_rd, 0);
    check("rst_state", state, S_FETCH);
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_md_start", md_start, 0);
`ifdef PC_CTRL_EXC_EN
    check("rst_epc_out", epc_out, 0);
    check("rst_exc_take", exc_take, 0);
`endif
    rst = 0;
    tick();
    check("rel_imem_rd", imem_rd, 1);
    fetch(0, OP_ALU, 0, 32'h0040_0000);
    check("alu_exec_rf", rf_we, 0);
    tick();
    check("alu_wb", state, S_WB);
    check("alu_rf_we", rf_we, 1);
    tick();
    check("alu_done", state, S_FETCH);
    check("alu_rf_off", rf_we, 0);
    fetch(2, OP_BRANCH, 0, 32'h0040_0004);
    br_taken = 1; btarget = 32'h0040_0102;
    tick();
    br_taken = 0;
    check("br_t_state", state, S_FETCH);
    check("br_t_pc", pc, 32'h0040_0100);
    fetch(0, OP_BRANCH, 0, 32'h0040_0100);
    btarget = 32'h0040_0500;
    tick();
    check("br_nt_state", state, S_FETCH);
    check("br_nt_pc", pc, 32'h0040_0104);
    fetch(0, OP_JUMP, 1, 32'h0040_0104);
    jtarget = 32'h0040_0203;
    tick();
    check("jal_wb", state, S_WB);
    check("jal_pc", pc, 32'h0040_0200);
    check("jal_rf_we", rf_we, 1);
    tick();
    check("jal_done", state, S_FETCH);
    fetch(0, OP_JREG, 0, 32'h0040_0200);
    rs_val = 32'h0040_0011;
    tick();
    check("jr_state", state, S_FETCH);
    check("jr_pc", pc, 32'h0040_0010);
    fetch(0, OP_LOAD, 0, 32'h0040_0010);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ld_state", state, S_MEM);
      check("ld_req", dmem_req, 1);
      check("ld_we", dmem_we, 0);
      dmem_ack = (i == 3);
      tick();
    end
    dmem_ack = 0;
    check("ld_wb", state, S_WB);
    check("ld_rf_we", rf_we, 1);
    tick();
    check("ld_done", state, S_FETCH);
    fetch(0, OP_STORE, 0, 32'h0040_0014);
    tick();
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_rf_mem", rf_we, 0);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    check("st_done", state, S_FETCH);
    check("st_rf_off", rf_we, 0);
    fetch(0, OP_MULDIV, 0, 32'h0040_0018);
    check("md_start", md_start, 1);
    md_busy = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("md_wait", state, S_MDWAIT);
      check("md_start_off", md_start, 0);
      if (i == 4) md_busy = 0;
      tick();
    end
    check("md_done", state, S_FETCH);
    check("md_pc", pc, 32'h0040_001C);
`ifdef PC_CTRL_EXC_EN
    fetch(0, OP_TRAP, 0, 32'h0040_001C);
    tick();
    check("trap_state", state, S_EXC);
    check("trap_take", exc_take, 1);
    tick();
    check("trap_done", state, S_FETCH);
    check("trap_pc", pc, 32'h0040_0004);
    check("trap_epc", epc_out, 32'h0040_001C);
    check("trap_take_off", exc_take, 0);
    eret = 1;
    fetch(0, OP_TRAP, 0, 32'h0040_0004);
    eret = 0; epc_in = 32'h0040_0014;
    tick();
    check("eret_state", state, S_EXC);
    tick();
    check("eret_pc", pc, 32'h0040_0014);
    check("eret_epc_keep", epc_out, 32'h0040_001C);
    pcx = 32'h0040_0014;
`else
    fetch(0, OP_TRAP, 0, 32'h0040_001C);
    tick();
    check("trap_nop_state", state, S_FETCH);
    check("trap_nop_pc", pc, 32'h0040_0020);
    pcx = 32'h0040_0020;
`endif
    fetch(0, OP_JUMP, 0, pcx);
    jtarget = 32'hFFFF_FFFC;
    tick();
    check("jmp_top_pc", pc, 32'hFFFF_FFFC);
    fetch(0, OP_LOAD, 0, 32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'h0);
    tick();
    check("rmem_req", dmem_req, 1);
    tick();
    check("rmem_req2", dmem_req, 1);
    dmem_ack = 1; rst = 1;
    #1;
    check("rmem_req_drop", dmem_req, 0);
    check("rmem_state", state, S_FETCH);
    check("rmem_pc", pc, 32'h0040_0000);
    check("rmem_imem_rd", imem_rd, 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_state", state, S_FETCH);
    check("post_rst_req", dmem_req, 0);
    check("post_rst_rd", imem_rd, 1);
    dmem_ack = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Multi-cycle sequencer for the 32-bit MIPS core: owns the program counter, walks every instruction through FETCH/DECODE/EXEC/MEM/WB, and selects the next PC (sequential, branch, jump, register jump, trap vector). Sits between instruction/data memory handshakes, the decoder, the multiply/divide unit and the register file, and issues their strobes.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0040_0004, trap entry address (used only with PC_CTRL_EXC_EN)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_rd  out  1  fetch request, held in FETCH until imem_ack
- imem_ack  in  1  instruction word valid this cycle
- ir_we  out  1  load instruction register (= FETCH & imem_ack)
- op_class  in  3  decoder class, valid in DECODE/EXEC: 0 ALU, 1 BRANCH, 2 JUMP, 3 JREG, 4 LOAD, 5 STORE, 6 MULDIV, 7 TRAP
- link  in  1  JUMP/JREG also writes link register (jal/jalr)
- eret  in  1  with TRAP class: return from exception
- br_taken  in  1  branch comparator result, valid in EXEC
- btarget, jtarget, rs_val  in  32 each  branch target, jump target, jr/jalr register value
- md_start  out  1  one-cycle start pulse to multiply/divide unit
- md_busy  in  1  multiply/divide in progress
- dmem_req  out  1  data access request, held in MEM until dmem_ack
- dmem_we  out  1  store qualifier on dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc  out  32  current PC register
- state  out  3  current state, debug
- epc_in  in  32  saved EPC from CP0 (PC_CTRL_EXC_EN only)
- exc_take  out  1  trap entry pulse; epc_out  out  32  address of trapping instruction (PC_CTRL_EXC_EN only)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, EXC=6.
- FETCH: imem_rd=1. On imem_ack: ir_we=1, pc <= pc+4, -> DECODE. Otherwise stay.
- DECODE: -> EXEC unconditionally (operand read cycle).
- EXEC by op_class:
  - ALU -> WB.
  - BRANCH: br_taken ? pc <= btarget; -> FETCH.
  - JUMP: pc <= jtarget; JREG: pc <= rs_val; link ? -> WB : -> FETCH.
  - LOAD/STORE -> MEM. MULDIV: md_start=1, -> MDWAIT.
  - TRAP: -> EXC with macro; without macro treated as NOP, -> FETCH.
- MEM: dmem_req=1, dmem_we=(STORE). On dmem_ack: LOAD -> WB, STORE -> FETCH.
- MDWAIT: stay while md_busy; -> FETCH when md_busy=0 (sampled from cycle after md_start).
- WB: rf_we=1 one cycle, -> FETCH.
- EXC: exc_take=1; eret ? pc <= epc_in : (epc_out <= pc-4, pc <= EXC_VECTOR); -> FETCH.
- Arithmetic: pc+4 and pc-4 modulo 2^32 (0xFFFF_FFFC+4 = 0). All loaded targets have bits [1:0] forced to 0.
- op_class/link/eret are latched at end of DECODE; changes afterwards are ignored.
- Illegal state encodings (7) -> FETCH.

## Timing
- Reset: state=FETCH, pc=RESET_PC, epc_out=0; imem_rd, ir_we, md_start, dmem_req, dmem_we, rf_we, exc_take all 0 while rst high (imem_rd rises first cycle after release).
- Strobes are Moore decodes of state except ir_we (Mealy on imem_ack).
- Zero-wait-state cycle counts (ack same cycle as request): ALU 4, BRANCH/JUMP 3, JAL 4, LOAD 5, STORE 4, MULDIV 4 + busy cycles, TRAP 4. Each memory wait cycle adds one.
- pc updates on the edge leaving FETCH/EXEC/EXC; new value visible next cycle.
- rst asserted mid-access drops imem_rd/dmem_req immediately (asynchronous); outstanding ack after release is ignored unless in the matching state.

## Configuration
- PC_CTRL_EXC_EN defined: EXC state, EXC_VECTOR, epc_in, exc_take, epc_out present; TRAP enters trap vector, TRAP+eret returns to epc_in.
- Undefined: ports and EXC state removed; TRAP class executes as NOP (3 cycles), state never reads 6.

## Structure
- Package pc_ctrl_pkg: state encodings, op_class codes, default RESET_PC/EXC_VECTOR.
- Sub-module pc_next_mux: combinational next-PC select (pc+4, btarget, jtarget, rs_val, vector, epc) with [1:0] masking; FSM stays in pc_ctrl.

## Test plan
- Reset, then ALU op, imem_ack immediate -> pc 0x0040_0000 -> 0x0040_0004, rf_we pulses in cycle 4, FETCH again cycle 5.
- BRANCH with br_taken=1, btarget=0x0040_0102 -> pc=0x0040_0100; br_taken=0 -> pc=0x0040_0004.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we pulse; STORE -> no rf_we.
- MULDIV, md_busy high 5 cycles -> md_start single pulse, return to FETCH cycle after md_busy falls.
- With PC_CTRL_EXC_EN: TRAP at 0x0040_0010 -> exc_take pulse, epc_out=0x0040_0010, pc=0x0040_0004; TRAP+eret, epc_in=0x0040_0014 -> pc=0x0040_0014.
- rst asserted during MEM wait -> dmem_req drops same cycle, pc=RESET_PC, state=FETCH; pc at 0xFFFF_FFFC fetch -> wraps to 0.
